fir0: RTL and testbench

FIR0 -- requirements
Module: fir0

---
 rtl/fir0.sv | 78 +++++++
 tb/tb_fir0.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fir0.sv
// fir0: 11-tap symmetric half-band low-pass FIR with fixed Q1.15 coefficients and one sample per clock.
// Y is registered and carries one cycle of latency from the d0 tap. Result is rounded half-up and saturated to the DATA_W range.
module fir0 #(
  parameter int DATA_W = 14,
  parameter int COEF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] X,
  output logic [DATA_W-1:0] Y
);

  localparam int NTAP  = 11;
  localparam int FRAC  = COEF_W - 1;
  localparam int ACC_W = DATA_W + COEF_W + 4;

  // h0..h5; the remaining taps mirror around h5
  localparam int H [0:5] = '{128, 0, -1920, 0, 9984, 16384};

  localparam logic signed [ACC_W-1:0] Y_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] Y_MIN = -Y_MAX - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) <<< (FRAC - 1);

  logic [DATA_W-1:0] d_q [NTAP];
  logic [DATA_W-1:0] d_d [NTAP];
  logic [DATA_W-1:0] y_q, y_d;

  logic signed [DATA_W:0]     pre;
  logic signed [COEF_W-1:0]   coef;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    rnd;
  logic signed [ACC_W-1:0]    scaled;

  always_comb begin
    acc  = '0;
    pre  = '0;
    coef = '0;
    // Mirrored taps share one coefficient, so pre-add them before the multiply
    for (int k = 0; k < 5; k++) begin
      pre  = (DATA_W+1)'($signed(d_q[k])) + (DATA_W+1)'($signed(d_q[NTAP-1-k]));
      coef = COEF_W'(H[k]);
      acc  = acc + ACC_W'(pre) * ACC_W'(coef);
    end
    coef   = COEF_W'(H[5]);
    acc    = acc + ACC_W'($signed(d_q[5])) * ACC_W'(coef);

    rnd    = acc + HALF;
    scaled = rnd >>> FRAC;

    if (scaled > Y_MAX) begin
      y_d = Y_MAX[DATA_W-1:0];
    end else if (scaled < Y_MIN) begin
      y_d = Y_MIN[DATA_W-1:0];
    end else begin
      y_d = scaled[DATA_W-1:0];
    end

    d_d[0] = X;
    for (int i = 1; i < NTAP; i++) begin
      d_d[i] = d_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAP; i++) begin
        d_q[i] <= '0;
      end
      y_q <= '0;
    end else begin
      d_q <= d_d;
      y_q <= y_d;
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_fir0.sv
// Directed bench for fir0: impulse, DC, saturation, mid-stream reset and random stream,
// with Y compared every cycle to a bit-accurate reference filter.
module tb_fir0;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] x;
  logic [13:0] y;

  int n_chk  = 0;
  int n_fail = 0;

  localparam int HM [11] = '{128, 0, -1920, 0, 9984, 16384, 9984, 0, -1920, 0, 128};

  int dm [11];
  int ym;
  int imp_exp [12] = '{4, 0, -59, 0, 305, 500, 305, 0, -59, 0, 4, 0};
  int sat_pat [11];

  always #5 clk = ~clk;

  fir0 dut (
    .clk   (clk),
    .reset (reset),
    .X     (x),
    .Y     (y)
  );

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    int diff;
    diff = obs - exp;
    n_chk++;
    if (diff > tol || diff < -tol) begin
      n_fail++;
      $display("FAIL %s: Y=%0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int golden();
    longint s;
    s = 0;
    for (int k = 0; k < 11; k++) begin
      s += longint'(HM[k]) * longint'(dm[k]);
    end
    s = (s + 64'sd16384) >>> 15;
    if (s > 8191)  s = 8191;
    if (s < -8192) s = -8192;
    return int'(s);
  endfunction

  // Drive one sample, advance one edge, update the reference, compare after the edge.
  task automatic cycle(input int xv, input bit rst, input int tol, input string tag);
    x     = 14'(xv);
    reset = rst;
    @(posedge clk);
    if (rst) begin
      ym = 0;
      for (int k = 0; k < 11; k++) dm[k] = 0;
    end else begin
      ym = golden();
      for (int k = 10; k > 0; k--) dm[k] = dm[k-1];
      dm[0] = xv;
    end
    @(negedge clk);
    check(tag, int'($signed(y)), ym, tol);
  endtask

  task automatic impulse(input string tag);
    cycle(1000, 1'b0, 0, tag);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1'b0, 0, tag);
      check({tag, "_seq"}, int'($signed(y)), imp_exp[i], 0);
    end
  endtask

  initial begin
    x     = '0;
    reset = 1'b1;
    for (int k = 0; k < 11; k++) dm[k] = 0;
    ym = 0;
    @(negedge clk);

    cycle(1234, 1'b1, 0, "reset");
    cycle(-77, 1'b1, 0, "reset");
    check("reset_y", int'($signed(y)), 0, 0);
    cycle(0, 1'b0, 0, "post_reset");
    check("post_reset_y", int'($signed(y)), 0, 0);

    impulse("impulse");

    for (int i = 0; i < 14; i++) cycle(8191, 1'b0, 0, "dc_pos");
    check("dc_pos_settle", int'($signed(y)), 8191, 0);
    for (int i = 0; i < 14; i++) cycle(-8192, 1'b0, 0, "dc_neg");
    check("dc_neg_settle", int'($signed(y)), -8192, 0);

    // Tap k holds the sample driven k cycles before the final load, so drive d10 first.
    for (int k = 0; k < 11; k++)
      sat_pat[k] = (HM[k] > 0) ? 8191 : ((HM[k] < 0) ? -8192 : 0);
    for (int k = 10; k >= 0; k--) cycle(sat_pat[k], 1'b0, 0, "sat_pos");
    cycle(0, 1'b0, 0, "sat_pos");
    check("sat_pos_y", int'($signed(y)), 8191, 0);

    for (int k = 0; k < 11; k++)
      sat_pat[k] = (HM[k] > 0) ? -8192 : ((HM[k] < 0) ? 8191 : 0);
    for (int k = 10; k >= 0; k--) cycle(sat_pat[k], 1'b0, 0, "sat_neg");
    cycle(0, 1'b0, 0, "sat_neg");
    check("sat_neg_y", int'($signed(y)), -8192, 0);

    for (int i = 0; i < 20; i++)
      cycle(int'($urandom_range(0, 16383)) - 8192, 1'b0, 2, "pre_rst_rand");
    cycle(4321, 1'b1, 0, "mid_reset");
    check("mid_reset_y", int'($signed(y)), 0, 0);
    impulse("impulse_after_reset");

    cycle(0, 1'b1, 0, "reset2");
    for (int i = 0; i < 40; i++)
      cycle(int'($urandom_range(0, 16383)) - 8192, 1'b0, 2, "rand");
    for (int i = 0; i < 12; i++)
      cycle(0, 1'b0, 2, "rand_flush");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
